// File: rtl/lif_neuron_array.sv
// ----------------------------------------------------------------------------
// lif_neuron_array
//
// Array of N_CH leaky integrate-and-fire neurons sharing one programmable
// threshold. Each channel keeps a W-bit membrane potential, a refractory
// counter and a registered spike flag. Every rising edge with step=1 applies
// one leak/integrate/fire update to all channels independently.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   step       in   integration enable, one update per edge while high
//   current    in   [N_CH*W] per-channel input current, channel i at [i*W +: W]
//   thresh_wr  in   threshold write strobe
//   thresh_in  in   [W] new threshold value
//   spike      out  [N_CH] per-channel one-cycle spike pulse (registered)
//   state      out  [N_CH*W] per-channel membrane potential (registered)
//   thresh     out  [W] current threshold (registered)
//
// Control semantics: step and thresh_wr are single-cycle strobes sampled on
// the rising edge. There is no backpressure; every sampled strobe takes
// effect on that edge. When both are high together, the neuron update uses
// the threshold that was in place before the edge.
// ----------------------------------------------------------------------------
module lif_neuron_array #(
  parameter int N_CH        = 8,
  parameter int W           = 8,
  parameter int LEAK_SHIFT  = 1,
  parameter int THRESH_INIT = 200,
  parameter int REFRAC      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [N_CH*W-1:0] current,
  input  logic              thresh_wr,
  input  logic [W-1:0]      thresh_in,
  output logic [N_CH-1:0]   spike,
  output logic [N_CH*W-1:0] state,
  output logic [W-1:0]      thresh
);

  // Refractory counter must be at least one bit even when REFRAC is 0.
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RW-1:0] REFRAC_LD = RW'(REFRAC);
  localparam logic [RW-1:0] R_ONE     = RW'(1);
  localparam logic [W-1:0]  TH_RST    = W'(THRESH_INIT);

  logic [W-1:0]    v_q   [N_CH];
  logic [W-1:0]    v_d   [N_CH];
  logic [RW-1:0]   r_q   [N_CH];
  logic [RW-1:0]   r_d   [N_CH];
  logic [N_CH-1:0] spike_q;
  logic [N_CH-1:0] spike_d;
  logic [W-1:0]    th_q;
  logic [W-1:0]    th_d;

  // Per-channel integration intermediates.
  logic [W:0]      sum_raw [N_CH];
  logic [W-1:0]    sum_sat [N_CH];

  always_comb begin
    th_d    = thresh_wr ? thresh_in : th_q;
    spike_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      // The leak term never exceeds v, so the subtraction stays in W bits;
      // only the addition of the current needs the extra carry bit.
      sum_raw[i] = {1'b0, v_q[i] - (v_q[i] >> LEAK_SHIFT)}
                 + {1'b0, current[i*W +: W]};
      sum_sat[i] = sum_raw[i][W] ? {W{1'b1}} : sum_raw[i][W-1:0];

      v_d[i] = v_q[i];
      r_d[i] = r_q[i];

      if (step) begin
        if (r_q[i] != '0) begin
          // Refractory: potential clamped to zero, current ignored.
          v_d[i] = '0;
          r_d[i] = r_q[i] - R_ONE;
        end else if (sum_sat[i] >= th_q) begin
          // Fire against the threshold held before this edge.
          spike_d[i] = 1'b1;
          v_d[i]     = '0;
          r_d[i]     = REFRAC_LD;
        end else begin
          v_d[i] = sum_sat[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      spike_q <= '0;
      th_q    <= TH_RST;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        v_q[i] <= v_d[i];
        r_q[i] <= r_d[i];
      end
      spike_q <= spike_d;
      th_q    <= th_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_state
    assign state[g*W +: W] = v_q[g];
  end

  assign spike  = spike_q;
  assign thresh = th_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// ----------------------------------------------------------------------------
// tb_lif_neuron_array
//
// Self-checking bench for lif_neuron_array with default parameters.
// A behavioural model predicts spike/thresh/state for every driven edge and
// pushes the prediction to exp_q; the prediction is popped and compared just
// after the edge. Directed scenarios add fixed expected values.
// ----------------------------------------------------------------------------
module tb_lif_neuron_array;

  localparam int N_CH = 8;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              step = 1'b0;
  logic [N_CH*W-1:0] current = '0;
  logic              thresh_wr = 1'b0;
  logic [W-1:0]      thresh_in = '0;
  logic [N_CH-1:0]   spike;
  logic [N_CH*W-1:0] state;
  logic [W-1:0]      thresh;

  int tests_run = 0;
  int tests_failed = 0;

  // {spike, thresh, state}
  logic [N_CH+W+N_CH*W-1:0] exp_q[$];

  int        m_v [N_CH];
  int        m_r [N_CH];
  int        m_th;
  logic [7:0] m_spk;

  lif_neuron_array #(
    .N_CH(N_CH), .W(W), .LEAK_SHIFT(1), .THRESH_INIT(200), .REFRAC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .current(current),
    .thresh_wr(thresh_wr), .thresh_in(thresh_in),
    .spike(spike), .state(state), .thresh(thresh)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model
  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_v[i] = 0;
      m_r[i] = 0;
    end
    m_spk = '0;
    m_th  = 200;
  endtask

  task automatic model_edge(input logic s, input logic [63:0] cur,
                            input logic wr, input logic [7:0] thi);
    int sum;
    for (int i = 0; i < N_CH; i++) begin
      if (s) begin
        if (m_r[i] > 0) begin
          m_v[i] = 0;
          m_r[i] = m_r[i] - 1;
          m_spk[i] = 1'b0;
        end else begin
          sum = m_v[i] - (m_v[i] / 2) + int'(cur[i*8 +: 8]);
          if (sum > 255) sum = 255;
          if (sum >= m_th) begin
            m_spk[i] = 1'b1;
            m_v[i] = 0;
            m_r[i] = 2;
          end else begin
            m_spk[i] = 1'b0;
            m_v[i] = sum;
          end
        end
      end else begin
        m_spk[i] = 1'b0;
      end
    end
    if (wr) m_th = int'(thi);
  endtask

  function automatic logic [79:0] model_pack();
    logic [63:0] st;
    logic [31:0] th32;
    logic [31:0] v32;
    for (int i = 0; i < N_CH; i++) begin
      v32 = m_v[i];
      st[i*8 +: 8] = v32[7:0];
    end
    th32 = m_th;
    return {m_spk, th32[7:0], st};
  endfunction

  // Scoreboard compare of one DUT output sample
  task automatic compare_out();
    logic [79:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_state",  state,  e[63:0]);
      check("sb_thresh", {56'd0, thresh}, {56'd0, e[71:64]});
      check("sb_spike",  {56'd0, spike},  {56'd0, e[79:72]});
    end
  endtask

  // Driver: one clock edge with given inputs, then sample at edge+1
  task automatic drive_cycle(input logic s, input logic [63:0] cur,
                             input logic wr, input logic [7:0] thi);
    step      = s;
    current   = cur;
    thresh_wr = wr;
    thresh_in = thi;
    model_edge(s, cur, wr, thi);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    compare_out();
    thresh_wr = 1'b0;
    step      = 1'b0;
  endtask

  // Asynchronous reset between edges; checked before any clock edge.
  task automatic do_reset();
    step      = 1'b0;
    thresh_wr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_state",  state, 64'd0);
    check("rst_spike",  {56'd0, spike}, 64'd0);
    check("rst_thresh", {56'd0, thresh}, 64'd200);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int leak_exp [11] = '{100, 150, 175, 188, 194, 197, 199, 0, 0, 0, 100};
  int leak_spk [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    model_reset();
    do_reset();

    // Leak integration on ch0
    for (int k = 0; k < 11; k++) begin
      drive_cycle(1'b1, 64'd100, 1'b0, 8'd0);
      check("leak_v",   {56'd0, state[7:0]}, 64'(leak_exp[k]));
      check("leak_spk", {63'd0, spike[0]},   64'(leak_spk[k]));
      check("leak_others", {8'd0, state[63:8]}, 64'd0);
    end

    // Reset in the middle of integration / refractory
    drive_cycle(1'b1, {$urandom, $urandom}, 1'b0, 8'd0);
    drive_cycle(1'b1, {$urandom, $urandom}, 1'b1, 8'd90);
    drive_cycle(1'b1, {$urandom, $urandom}, 1'b0, 8'd0);
    do_reset();

    // Saturation on ch1
    drive_cycle(1'b0, 64'd0, 1'b1, 8'd255);
    check("sat_th", {56'd0, thresh}, 64'd255);
    drive_cycle(1'b1, 64'd200 << 8, 1'b0, 8'd0);
    check("sat_v1", {56'd0, state[15:8]}, 64'd200);
    drive_cycle(1'b1, 64'd200 << 8, 1'b0, 8'd0);
    check("sat_spk", {63'd0, spike[1]}, 64'd1);
    check("sat_v2",  {56'd0, state[15:8]}, 64'd0);

    // Step gating on ch0
    do_reset();
    drive_cycle(1'b1, 64'd100, 1'b0, 8'd0);
    drive_cycle(1'b1, 64'd100, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, {$urandom, $urandom}, 1'b0, 8'd0);
      check("gate_v",   {56'd0, state[7:0]}, 64'd150);
      check("gate_spk", {56'd0, spike},      64'd0);
    end
    drive_cycle(1'b1, 64'd100, 1'b0, 8'd0);
    check("gate_resume", {56'd0, state[7:0]}, 64'd175);

    // Threshold write colliding with step on ch2
    do_reset();
    for (int k = 0; k < 7; k++) drive_cycle(1'b1, 64'd100 << 16, 1'b0, 8'd0);
    check("coll_pre", {56'd0, state[23:16]}, 64'd199);
    drive_cycle(1'b1, 64'd100 << 16, 1'b1, 8'd250);
    check("coll_spk", {63'd0, spike[2]}, 64'd1);
    check("coll_th",  {56'd0, thresh},  64'd250);

    // Zero threshold: all channels spike every REFRAC+1 steps
    do_reset();
    drive_cycle(1'b0, 64'd0, 1'b1, 8'd0);
    for (int k = 0; k < 9; k++) begin
      drive_cycle(1'b1, 64'd0, 1'b0, 8'd0);
      check("th0_spk", {56'd0, spike}, (k % 3 == 0) ? 64'hFF : 64'h00);
    end

    // Random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive_cycle($urandom_range(0, 3) != 0,
                  {$urandom, $urandom} >> $urandom_range(0, 2),
                  $urandom_range(0, 15) == 0,
                  8'($urandom_range(0, 255)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of leaky integrate-and-fire neurons for the neuromorphic tile. Each of `N_CH` channels integrates an unsigned input current into a `W`-bit membrane potential with a shift-based leak. A channel emits a one-cycle spike when its potential reaches a runtime-programmable threshold, then enters a fixed refractory period. The array sits between the input pins and the spike/state outputs of the tile top level, and is the generalised successor to the fixed 8-channel LIF instance array.

## Interface

- `N_CH`, 8, number of neuron channels
- `W`, 8, membrane potential, current and threshold width in bits
- `LEAK_SHIFT`, 1, leak amount per step is `state >> LEAK_SHIFT` (range 1..W-1)
- `THRESH_INIT`, 200, threshold value loaded at reset
- `REFRAC`, 2, refractory steps after a spike (0 disables refractory)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `step`  in  1  integration enable; one update per rising edge while high
- `current`  in  N_CH*W  per-channel input current; channel i at `[i*W +: W]`
- `thresh_wr`  in  1  threshold write strobe
- `thresh_in`  in  W  new threshold value
- `spike`  out  N_CH  per-channel spike pulse, registered
- `state`  out  N_CH*W  per-channel membrane potential, registered; channel i at `[i*W +: W]`
- `thresh`  out  W  current threshold, registered

## Operation

- Per channel, registers: potential `v` (W bits), refractory counter `r` (width `$clog2(REFRAC+1)`, minimum 1), spike flag.
- Shared register: threshold `th`.
- Update on a rising edge with `step=1`, evaluated independently per channel:
  - Refractory (`r != 0`): `v <= 0`, `r <= r-1`, `spike <= 0`. Current is ignored.
  - Integrating (`r == 0`): `sum = (v - (v >> LEAK_SHIFT)) + current`, computed in W+1 bits. `sum` saturates to `2^W-1`.
    - If `sum >= th`: `spike <= 1`, `v <= 0`, `r <= REFRAC`.
    - Else: `spike <= 0`, `v <= sum`.
- Rising edge with `step=0`: `v` and `r` hold; `spike <= 0`.
- Threshold: on a rising edge with `thresh_wr=1`, `th <= thresh_in`.
  - When `thresh_wr` and `step` are both high on the same edge, the update compares against the old `th`.
- `th = 0`: every non-refractory step spikes.
- Compare is unsigned and inclusive (`>=`).
- Subtraction never underflows, because the leak is never larger than `v`.

## Timing

- Reset (async assert, sync-released by the top level):
  - `v = 0`, `r = 0`, `spike = 0`, `th = THRESH_INIT` on all channels.
  - Outputs therefore show `state = 0`, `spike = 0`, `thresh = THRESH_INIT`.
- Latency: the `current` value sampled at edge k is reflected in `state` and `spike` immediately after edge k. This is one register stage; there is no combinational path from inputs to outputs.
- `spike` stays high for exactly one cycle per crossing, including when `step` is held high continuously.
- After a spike at step n, steps n+1..n+REFRAC hold `v = 0`. Integration resumes at step n+REFRAC+1.
- Refractory steps are counted only on edges with `step=1`. Cycles with `step=0` do not advance `r`.
- Reset asserted mid-refractory or mid-integration clears all state within the same cycle; the threshold returns to `THRESH_INIT`.
- Channels do not interact; simultaneous spikes on any subset of channels are legal.

## Test plan

- Reset: assert `rst_n=0` mid-run, then release.
  - -> `spike=0`, all `state=0`, `thresh=200`, with no clock edge required.
- Leak integration (defaults), ch0 `current=100`, `step=1` held:
  - -> ch0 `state` after steps 1..7 is 100, 150, 175, 188, 194, 197, 199.
  - -> step 8: `spike[0]=1` for one cycle and `state=0`.
  - -> steps 9–10: `state=0`, `spike=0`.
  - -> step 11: `state=100`.
  - -> other channels with `current=0` remain 0.
- Saturation: write `th=255`, ch1 `current=200`.
  - -> step 1 `state=200`.
  - -> step 2: sum 300 saturates to 255 -> `spike[1]=1`, `state=0`.
- Step gating: ch0 at 150, then `step=0` for 5 cycles.
  - -> `state` holds 150, `spike=0`.
  - -> next `step=1` with `current=100` -> 175.
- Write/step collision: ch2 at 199 with `th=200`, `current=100`. Same edge: `thresh_wr=1`, `thresh_in=250`, `step=1`.
  - -> spike fires (old threshold 200), `thresh=250` afterwards.
- All-channel spike with `th=0`: all currents 0.
  - -> every non-refractory step gives `spike=8'hFF` with period REFRAC+1 = 3 steps.
